// File: rtl/i2c_port_target.sv
// i2c_port_target: write-only I2C target that latches each received data byte
// onto an 8-bit parallel port, in the manner of a PCF8574 output expander.
module i2c_port_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h27,
  parameter logic [7:0] PORT_RESET  = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_pull,
  output logic [7:0] port_out,
  output logic       byte_valid,
  output logic       addr_hit,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_DATA,
    S_DATA_ACK,
    S_IGNORE
  } state_t;

  state_t     state;
  logic       scl_m, scl_s, scl_p;
  logic       sda_m, sda_s, sda_p;
  logic [7:0] shift;
  logic [7:0] shift_nx;
  logic [2:0] bit_cnt;
  logic       start_det, stop_det, scl_rise, scl_fall;

  // Two-stage synchronisers plus a previous-sample stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_m <= 1'b1;
      scl_s <= 1'b1;
      scl_p <= 1'b1;
      sda_m <= 1'b1;
      sda_s <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_m <= scl_in;
      scl_s <= scl_m;
      scl_p <= scl_s;
      sda_m <= sda_in;
      sda_s <= sda_m;
      sda_p <= sda_s;
    end
  end

  // Bus condition and clock edge decode.
  always_comb begin
    start_det = scl_s & scl_p & sda_p & ~sda_s;
    stop_det  = scl_s & scl_p & ~sda_p & sda_s;
    scl_rise  = scl_s & ~scl_p;
    scl_fall  = ~scl_s & scl_p;
    shift_nx  = {shift[6:0], sda_s};
  end

  // Protocol FSM; START/STOP take priority over SCL edge actions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      sda_pull   <= 1'b0;
      port_out   <= PORT_RESET;
      byte_valid <= 1'b0;
      addr_hit   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      addr_hit   <= 1'b0;
      if (start_det) begin
        state    <= S_ADDR;
        bit_cnt  <= '0;
        sda_pull <= 1'b0;
      end else if (stop_det) begin
        state    <= S_IDLE;
        bit_cnt  <= '0;
        sda_pull <= 1'b0;
        busy     <= 1'b0;
      end else begin
        if (scl_rise) begin
          shift   <= shift_nx;
          bit_cnt <= bit_cnt + 3'd1;
        end
        case (state)
          S_ADDR: begin
            if (scl_rise && bit_cnt == 3'd7) begin
              if (shift_nx[7:1] == TARGET_ADDR && !shift_nx[0]) begin
                state    <= S_ADDR_ACK;
                addr_hit <= 1'b1;
                busy     <= 1'b1;
              end else begin
                state <= S_IGNORE;
              end
            end
          end
          S_ADDR_ACK, S_DATA_ACK: begin
            // First fall (end of bit 8) drives ACK, second fall (end of 9th clock) releases it.
            if (scl_fall) begin
              if (!sda_pull) begin
                sda_pull <= 1'b1;
              end else begin
                sda_pull <= 1'b0;
                bit_cnt  <= '0;
                state    <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (scl_rise && bit_cnt == 3'd7) begin
              port_out   <= shift_nx;
              byte_valid <= 1'b1;
              state      <= S_DATA_ACK;
            end
          end
          default: begin
            sda_pull <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_port_target.sv
// Directed bench for i2c_port_target driven by a bit-banged I2C master.
module tb_i2c_port_target;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       scl_in, sda_in;
  logic       sda_pull;
  logic [7:0] port_out;
  logic       byte_valid, addr_hit, busy;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int bv_tot = 0, ah_tot = 0, pull_tot = 0, busy_tot = 0;

  // Open-drain bus: the target can only pull SDA low.
  assign scl_in = m_scl;
  assign sda_in = m_sda & ~sda_pull;

  i2c_port_target #(.TARGET_ADDR(7'h27), .PORT_RESET(8'hFF)) dut (
    .clk        (clk),
    .rst        (rst),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .sda_pull   (sda_pull),
    .port_out   (port_out),
    .byte_valid (byte_valid),
    .addr_hit   (addr_hit),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Count high cycles of each output.
  always @(negedge clk) begin
    if (byte_valid) bv_tot++;
    if (addr_hit) ah_tot++;
    if (sda_pull) pull_tot++;
    if (busy) busy_tot++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_scl = 1'b1;
    m_sda = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(3);
  endtask

  task automatic bus_start();
    tick(1);
    m_sda = 1'b1;
    tick(4);
    m_scl = 1'b1;
    tick(5);
    m_sda = 1'b0;
    tick(5);
    m_scl = 1'b0;
  endtask

  task automatic bus_stop();
    tick(1);
    m_sda = 1'b0;
    tick(4);
    m_scl = 1'b1;
    tick(5);
    m_sda = 1'b1;
    tick(5);
  endtask

  task automatic send_bit(input logic b);
    tick(1);
    m_sda = b;
    tick(4);
    m_scl = 1'b1;
    tick(5);
    m_scl = 1'b0;
  endtask

  // Sends 8 bits then the 9th clock; acked=1 only if sda_pull held through its high phase.
  task automatic send_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    tick(1);
    m_sda = 1'b1;
    tick(4);
    m_scl = 1'b1;
    acked = 1'b1;
    repeat (5) begin
      tick(1);
      if (!sda_pull) acked = 1'b0;
    end
    m_scl = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cmp_cnt++; if (sda_pull !== 1'b0) begin err_cnt++; $display("FAIL reset_sda_pull: got %b expected 0", sda_pull); end
    cmp_cnt++; if (port_out !== 8'hFF) begin err_cnt++; $display("FAIL reset_port_out: got %h expected ff", port_out); end
    cmp_cnt++; if (byte_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_byte_valid: got %b expected 0", byte_valid); end
    cmp_cnt++; if (addr_hit !== 1'b0) begin err_cnt++; $display("FAIL reset_addr_hit: got %b expected 0", addr_hit); end
    cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic_write();
    logic a0, a1;
    int bv0, ah0;
    do_reset();
    bv0 = bv_tot; ah0 = ah_tot;
    bus_start();
    send_byte(8'h4E, a0);
    cmp_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL basic_busy_mid: got %b expected 1", busy); end
    send_byte(8'hA5, a1);
    bus_stop();
    cmp_cnt++; if (a0 !== 1'b1) begin err_cnt++; $display("FAIL basic_addr_ack: got %b expected 1", a0); end
    cmp_cnt++; if (a1 !== 1'b1) begin err_cnt++; $display("FAIL basic_data_ack: got %b expected 1", a1); end
    cmp_cnt++; if (port_out !== 8'hA5) begin err_cnt++; $display("FAIL basic_port_out: got %h expected a5", port_out); end
    cmp_cnt++; if (bv_tot - bv0 !== 1) begin err_cnt++; $display("FAIL basic_byte_valid_cycles: got %0d expected 1", bv_tot - bv0); end
    cmp_cnt++; if (ah_tot - ah0 !== 1) begin err_cnt++; $display("FAIL basic_addr_hit_cycles: got %0d expected 1", ah_tot - ah0); end
    cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL basic_busy_after_stop: got %b expected 0", busy); end
  endtask

  task automatic test_addr_miss();
    logic a0, a1;
    int pl0, ah0, bs0;
    do_reset();
    pl0 = pull_tot; ah0 = ah_tot; bs0 = busy_tot;
    bus_start();
    send_byte(8'h40, a0);
    send_byte(8'h3C, a1);
    bus_stop();
    cmp_cnt++; if (pull_tot - pl0 !== 0) begin err_cnt++; $display("FAIL miss_sda_pull_cycles: got %0d expected 0", pull_tot - pl0); end
    cmp_cnt++; if (port_out !== 8'hFF) begin err_cnt++; $display("FAIL miss_port_out: got %h expected ff", port_out); end
    cmp_cnt++; if (ah_tot - ah0 !== 0) begin err_cnt++; $display("FAIL miss_addr_hit_cycles: got %0d expected 0", ah_tot - ah0); end
    cmp_cnt++; if (busy_tot - bs0 !== 0) begin err_cnt++; $display("FAIL miss_busy_cycles: got %0d expected 0", busy_tot - bs0); end
  endtask

  task automatic test_multi_byte();
    logic [7:0] data [3] = '{8'h11, 8'h22, 8'h33};
    logic a;
    int acks, bv0;
    acks = 0; bv0 = bv_tot;
    bus_start();
    send_byte(8'h4E, a);
    if (a) acks++;
    for (int i = 0; i < 3; i++) begin
      send_byte(data[i], a);
      if (a) acks++;
    end
    bus_stop();
    cmp_cnt++; if (acks !== 4) begin err_cnt++; $display("FAIL multi_acks: got %0d expected 4", acks); end
    cmp_cnt++; if (bv_tot - bv0 !== 3) begin err_cnt++; $display("FAIL multi_byte_valid_cycles: got %0d expected 3", bv_tot - bv0); end
    cmp_cnt++; if (port_out !== 8'h33) begin err_cnt++; $display("FAIL multi_port_out: got %h expected 33", port_out); end
  endtask

  task automatic test_read_request();
    logic a0, a1;
    int pl0, ah0, bv0, bs0;
    pl0 = pull_tot; ah0 = ah_tot; bv0 = bv_tot; bs0 = busy_tot;
    bus_start();
    send_byte(8'h4F, a0);
    send_byte(8'h00, a1);
    bus_stop();
    cmp_cnt++; if (a0 !== 1'b0) begin err_cnt++; $display("FAIL read_nack: got %b expected 0", a0); end
    cmp_cnt++; if (pull_tot - pl0 !== 0) begin err_cnt++; $display("FAIL read_sda_pull_cycles: got %0d expected 0", pull_tot - pl0); end
    cmp_cnt++; if (ah_tot - ah0 !== 0) begin err_cnt++; $display("FAIL read_addr_hit_cycles: got %0d expected 0", ah_tot - ah0); end
    cmp_cnt++; if (bv_tot - bv0 !== 0) begin err_cnt++; $display("FAIL read_byte_valid_cycles: got %0d expected 0", bv_tot - bv0); end
    cmp_cnt++; if (busy_tot - bs0 !== 0) begin err_cnt++; $display("FAIL read_busy_cycles: got %0d expected 0", busy_tot - bs0); end
    cmp_cnt++; if (port_out !== 8'h33) begin err_cnt++; $display("FAIL read_port_out: got %h expected 33", port_out); end
  endtask

  task automatic test_abort_recovery();
    logic a0, a1, a2;
    int bv0;
    bv0 = bv_tot;
    bus_start();
    send_byte(8'h4E, a0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    bus_stop();
    cmp_cnt++; if (bv_tot - bv0 !== 0) begin err_cnt++; $display("FAIL abort_byte_valid_cycles: got %0d expected 0", bv_tot - bv0); end
    cmp_cnt++; if (port_out !== 8'h33) begin err_cnt++; $display("FAIL abort_port_out: got %h expected 33", port_out); end
    cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL abort_busy: got %b expected 0", busy); end
    bus_start();
    send_byte(8'h4E, a1);
    send_byte(8'h5A, a2);
    bus_stop();
    cmp_cnt++; if (a2 !== 1'b1) begin err_cnt++; $display("FAIL recover_data_ack: got %b expected 1", a2); end
    cmp_cnt++; if (port_out !== 8'h5A) begin err_cnt++; $display("FAIL recover_port_out: got %h expected 5a", port_out); end
  endtask

  task automatic test_reset_during_ack();
    logic a0, a1;
    int waited;
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(8'h4E >> i);
    tick(1);
    m_sda = 1'b1;
    waited = 0;
    while (!sda_pull && waited < 10) begin
      tick(1);
      waited++;
    end
    cmp_cnt++; if (sda_pull !== 1'b1) begin err_cnt++; $display("FAIL rstack_pull_seen: got %b expected 1", sda_pull); end
    rst = 1'b1;
    tick(1);
    cmp_cnt++; if (sda_pull !== 1'b0) begin err_cnt++; $display("FAIL rstack_sda_pull: got %b expected 0", sda_pull); end
    cmp_cnt++; if (port_out !== 8'hFF) begin err_cnt++; $display("FAIL rstack_port_out: got %h expected ff", port_out); end
    rst = 1'b0;
    m_scl = 1'b1;
    tick(10);
    bus_start();
    send_byte(8'h4E, a0);
    send_byte(8'h81, a1);
    bus_stop();
    cmp_cnt++; if (a1 !== 1'b1) begin err_cnt++; $display("FAIL rstack_after_ack: got %b expected 1", a1); end
    cmp_cnt++; if (port_out !== 8'h81) begin err_cnt++; $display("FAIL rstack_after_port_out: got %h expected 81", port_out); end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_addr_miss();
    test_multi_byte();
    test_read_request();
    test_abort_recovery();
    test_reset_during_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
